// File: rtl/axi_pkg.sv
// Shared AXI master definitions for the read and write directions.
// Holds the state enums and the fixed AXI encodings used by both.
package axi_pkg;

  typedef enum logic [2:0] {
    WrIdle,
    WrLoadData,
    WrSendAddrData,
    WrWaitResp,
    WrDone
  } WriteState_t;

  typedef enum logic [1:0] {
    RdIdle,
    RdSendAddr,
    RdWaitData,
    RdDone
  } ReadState_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;
  localparam logic [2:0] AXI_SIZE_4B    = 3'd2;

endpackage

// File: rtl/axi_interface_write.sv
// AXI4 write master: takes a (start address, word count) request and issues one
// single-beat write per user word at incrementing addresses.
module axi_interface_write
  import axi_pkg::*;
#(
  parameter int unsigned ID_W       = 6,
  parameter int unsigned BEAT_BYTES = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     write_addr_in,
  input  logic [31:0]     write_len_in,
  input  logic            write_en_in,
  input  logic [31:0]     write_data_in,
  input  logic            write_data_valid_in,
  output logic            write_data_ready_out,
  output logic            busy,
  output logic            done,
  output logic            error,
  output logic [ID_W-1:0] m00_axi_awid,
  output logic [31:0]     m00_axi_awaddr,
  output logic [7:0]      m00_axi_awlen,
  output logic [2:0]      m00_axi_awsize,
  output logic [1:0]      m00_axi_awburst,
  output logic            m00_axi_awlock,
  output logic [3:0]      m00_axi_awcache,
  output logic [2:0]      m00_axi_awprot,
  output logic [3:0]      m00_axi_awqos,
  output logic            m00_axi_awvalid,
  input  logic            m00_axi_awready,
  output logic [31:0]     m00_axi_wdata,
  output logic [3:0]      m00_axi_wstrb,
  output logic            m00_axi_wlast,
  output logic            m00_axi_wvalid,
  input  logic            m00_axi_wready,
  input  logic [ID_W-1:0] m00_axi_bid,
  input  logic [1:0]      m00_axi_bresp,
  input  logic            m00_axi_bvalid,
  output logic            m00_axi_bready
);

  localparam logic [2:0] AWSIZE = (BEAT_BYTES == 4) ? AXI_SIZE_4B : 3'($clog2(BEAT_BYTES));

  WriteState_t r_state;
  WriteState_t w_state_next;
  logic [31:0] r_addr;
  logic [31:0] r_cntr;
  logic [31:0] r_data;
  logic        r_error;
  logic        r_aw_done;
  logic        r_w_done;
  logic        w_aw_ok;
  logic        w_w_ok;
  logic        w_unused_bid;

  assign w_unused_bid = ^m00_axi_bid;

  assign m00_axi_awid    = '0;
  assign m00_axi_awlen   = 8'd0;
  assign m00_axi_awsize  = AWSIZE;
  assign m00_axi_awburst = AXI_BURST_INCR;
  assign m00_axi_awlock  = 1'b0;
  assign m00_axi_awcache = 4'd0;
  assign m00_axi_awprot  = 3'd0;
  assign m00_axi_awqos   = 4'd0;
  assign m00_axi_wstrb   = 4'hF;
  assign m00_axi_awaddr  = r_addr;
  assign m00_axi_wdata   = r_data;

  // Each valid is held until its own handshake, independent of the other channel.
  assign m00_axi_awvalid      = (r_state == WrSendAddrData) && !r_aw_done;
  assign m00_axi_wvalid       = (r_state == WrSendAddrData) && !r_w_done;
  assign m00_axi_wlast        = m00_axi_wvalid;
  assign m00_axi_bready       = (r_state == WrWaitResp);
  assign write_data_ready_out = (r_state == WrLoadData);
  assign busy                 = (r_state != WrIdle);
  assign done                 = (r_state == WrDone);
  assign error                = r_error;

  assign w_aw_ok = r_aw_done || (m00_axi_awvalid && m00_axi_awready);
  assign w_w_ok  = r_w_done || (m00_axi_wvalid && m00_axi_wready);

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      WrIdle: begin
        if (write_en_in) w_state_next = (write_len_in == 32'd0) ? WrDone : WrLoadData;
      end
      WrLoadData: begin
        if (write_data_valid_in) w_state_next = WrSendAddrData;
      end
      WrSendAddrData: begin
        if (w_aw_ok && w_w_ok) w_state_next = WrWaitResp;
      end
      WrWaitResp: begin
        if (m00_axi_bvalid) w_state_next = (r_cntr == 32'd0) ? WrDone : WrLoadData;
      end
      WrDone:  w_state_next = WrIdle;
      default: w_state_next = WrIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= WrIdle;
      r_addr    <= 32'd0;
      r_cntr    <= 32'd0;
      r_data    <= 32'd0;
      r_error   <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      case (r_state)
        WrIdle: begin
          if (write_en_in) begin
            r_addr  <= write_addr_in;
            r_cntr  <= write_len_in - 32'd1;
            r_error <= 1'b0;
          end
        end
        WrLoadData: begin
          if (write_data_valid_in) r_data <= write_data_in;
        end
        WrSendAddrData: begin
          if (w_aw_ok && w_w_ok) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
          end else begin
            r_aw_done <= w_aw_ok;
            r_w_done  <= w_w_ok;
          end
        end
        WrWaitResp: begin
          if (m00_axi_bvalid) begin
            if (m00_axi_bresp != AXI_RESP_OKAY) r_error <= 1'b1;
            if (r_cntr != 32'd0) begin
              r_cntr <= r_cntr - 32'd1;
              r_addr <= r_addr + 32'(BEAT_BYTES);
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_interface_write.sv
// Bench for axi_interface_write: directed requests against a simple AXI slave,
// with an address/data/error expectation model checked every cycle.
module tb_axi_interface_write;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] write_addr_in = '0;
  logic [31:0] write_len_in = '0;
  logic        write_en_in = 1'b0;
  logic [31:0] write_data_in;
  logic        write_data_valid_in;
  logic        write_data_ready_out;
  logic        busy, done, error;
  logic [5:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic        awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic [3:0]  awqos;
  logic        awvalid, awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready;
  logic [5:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  always #5 clk = ~clk;

  axi_interface_write #(.ID_W(6), .BEAT_BYTES(4)) dut (
    .clk(clk), .rst(rst),
    .write_addr_in(write_addr_in), .write_len_in(write_len_in), .write_en_in(write_en_in),
    .write_data_in(write_data_in), .write_data_valid_in(write_data_valid_in),
    .write_data_ready_out(write_data_ready_out),
    .busy(busy), .done(done), .error(error),
    .m00_axi_awid(awid), .m00_axi_awaddr(awaddr), .m00_axi_awlen(awlen),
    .m00_axi_awsize(awsize), .m00_axi_awburst(awburst), .m00_axi_awlock(awlock),
    .m00_axi_awcache(awcache), .m00_axi_awprot(awprot), .m00_axi_awqos(awqos),
    .m00_axi_awvalid(awvalid), .m00_axi_awready(awready),
    .m00_axi_wdata(wdata), .m00_axi_wstrb(wstrb), .m00_axi_wlast(wlast),
    .m00_axi_wvalid(wvalid), .m00_axi_wready(wready),
    .m00_axi_bid(bid), .m00_axi_bresp(bresp), .m00_axi_bvalid(bvalid),
    .m00_axi_bready(bready)
  );

  int checks = 0;
  int errors = 0;

  // Expectation model: per-request queues of (address, data) and the sticky error.
  logic [31:0] exp_addr[$];
  logic [31:0] exp_data[$];
  logic        err_exp = 1'b0;
  int          done_cnt = 0;
  int          skew = 0;
  logic [31:0] last_awaddr = '0;
  logic [31:0] last_wdata = '0;

  logic [31:0] wtab[8];
  logic [1:0]  resp_tab[8];
  logic [31:0] feed_q[$];
  int          aw_delay = 0;
  int          stall = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  // Slave and data feeder: sample handshakes at negedge, update just after posedge.
  bit s_aw, s_w, s_b, s_d, aw_got, w_got;
  int beat, aw_wait;
  initial begin
    awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = '0;
    write_data_valid_in = 0; write_data_in = '0;
    aw_got = 0; w_got = 0; beat = 0; aw_wait = 0;
    forever begin
      @(negedge clk);
      s_aw = awvalid && awready;
      s_w  = wvalid && wready;
      s_b  = bvalid && bready;
      s_d  = write_data_valid_in && write_data_ready_out;
      @(posedge clk);
      #1;
      if (!rst) begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0; write_data_valid_in = 0;
        aw_got = 0; w_got = 0; beat = 0; aw_wait = 0;
        feed_q.delete();
        continue;
      end
      if (s_d && feed_q.size() > 0) void'(feed_q.pop_front());
      if (s_aw) aw_got = 1;
      if (s_w) w_got = 1;
      if (!busy) beat = 0;
      if (s_b) begin
        bvalid = 0; bresp = 0; aw_got = 0; w_got = 0; beat++;
      end else if (aw_got && w_got && !bvalid) begin
        bvalid = 1; bresp = resp_tab[beat % 8];
      end
      awready = awvalid && (aw_wait >= aw_delay);
      if (awready) aw_wait = 0;
      else if (awvalid) aw_wait++;
      wready = wvalid;
      if (feed_q.size() > 0) begin
        if (stall > 0) begin
          write_data_valid_in = 0; stall--;
        end else begin
          write_data_valid_in = 1; write_data_in = feed_q[0];
        end
      end else begin
        write_data_valid_in = 0;
      end
    end
  end

  // Compare process: protocol rules and model expectations every cycle.
  bit aw_acc, w_acc, prev_aw_pend, prev_w_pend, prev_done;
  logic [31:0] prev_awaddr, prev_wdata;
  initial begin
    aw_acc = 0; w_acc = 0; prev_aw_pend = 0; prev_w_pend = 0; prev_done = 0;
    forever begin
      @(negedge clk);
      if (!rst || !busy) begin aw_acc = 0; w_acc = 0; end
      if (!rst) begin
        prev_aw_pend = 0; prev_w_pend = 0; prev_done = 0;
        continue;
      end
      if (!busy) check("idle_quiet", {awvalid, wvalid, bready, write_data_ready_out, done}, 5'b0);
      check("consts", {awid, awlen, awsize, awburst, awlock, awcache, awprot, awqos, wstrb},
            {6'd0, 8'd0, 3'd2, 2'b01, 1'b0, 4'd0, 3'd0, 4'd0, 4'hF});
      check("wlast", wlast, wvalid);
      if (awvalid) check("aw_dup", aw_acc, 0);
      if (wvalid) check("w_dup", w_acc, 0);
      if (bready) check("bready_early", aw_acc && w_acc, 1);
      if (write_data_ready_out) check("load_quiet", {awvalid, wvalid, bready}, 3'b0);
      if (prev_aw_pend) check("aw_hold", {awvalid, awaddr}, {1'b1, prev_awaddr});
      if (prev_w_pend) check("w_hold", {wvalid, wdata}, {1'b1, prev_wdata});
      if (prev_done) check("busy_after_done", busy, 0);
      if (awvalid && !wvalid) skew++;
      if (awvalid && awready) begin
        check("aw_expected", exp_addr.size() > 0, 1);
        if (exp_addr.size() > 0) check("awaddr", awaddr, exp_addr.pop_front());
        last_awaddr = awaddr;
        aw_acc = 1;
      end
      if (wvalid && wready) begin
        check("w_expected", exp_data.size() > 0, 1);
        if (exp_data.size() > 0) check("wdata", wdata, exp_data.pop_front());
        last_wdata = wdata;
        w_acc = 1;
      end
      if (bvalid && bready) begin aw_acc = 0; w_acc = 0; end
      if (done) begin
        done_cnt++;
        check("error_at_done", error, err_exp);
        check("beats_left", exp_addr.size() + exp_data.size(), 0);
      end
      prev_aw_pend = awvalid && !awready;
      prev_w_pend  = wvalid && !wready;
      prev_awaddr  = awaddr;
      prev_wdata   = wdata;
      prev_done    = done;
    end
  end

  task automatic start(input logic [31:0] a, input logic [31:0] n);
    err_exp = 0;
    for (int i = 0; i < int'(n); i++) begin
      exp_addr.push_back(a + 32'(i * 4));
      exp_data.push_back(wtab[i]);
      feed_q.push_back(wtab[i]);
      if (resp_tab[i] != 2'b00) err_exp = 1;
    end
    @(posedge clk); #1;
    write_addr_in = a; write_len_in = n; write_en_in = 1;
    @(posedge clk); #1;
    write_en_in = 0;
  endtask

  task automatic wait_done(input int budget);
    int d0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt > d0) break;
    end
    check("done_timeout", done_cnt > d0, 1);
  endtask

  initial begin
    int d0;
    bit seen;
    #400000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0;
    bit seen;
    for (int i = 0; i < 8; i++) begin wtab[i] = '0; resp_tab[i] = 2'b00; end
    repeat (2) @(posedge clk);
    #1 rst = 1;
    @(negedge clk);
    check("rst_status", {busy, done, error}, 3'b0);
    check("rst_valids", {awvalid, wvalid, bready, write_data_ready_out}, 4'b0);

    // Single write
    wtab[0] = 32'hDEADBEEF;
    d0 = done_cnt;
    start(32'h1000, 1);
    wait_done(50);
    repeat (3) @(negedge clk);
    check("t1_done_once", done_cnt - d0, 1);
    check("t1_awaddr", last_awaddr, 32'h1000);
    check("t1_wdata", last_wdata, 32'hDEADBEEF);
    check("t1_error", error, 0);

    // Three-word burst
    wtab[0] = 32'd1; wtab[1] = 32'd2; wtab[2] = 32'd3;
    d0 = done_cnt;
    start(32'h2000, 3);
    wait_done(80);
    repeat (3) @(negedge clk);
    check("t2_done_once", done_cnt - d0, 1);
    check("t2_last_awaddr", last_awaddr, 32'h2008);
    check("t2_last_wdata", last_wdata, 32'd3);

    // Skewed readys: awready held low for 3 cycles
    aw_delay = 3; skew = 0;
    wtab[0] = 32'hA5A50001;
    start(32'h4000, 1);
    wait_done(50);
    repeat (2) @(negedge clk);
    check("t3_skew_cycles", skew, 3);
    aw_delay = 0;

    // Error on the second beat; all beats still go out
    wtab[0] = 32'd7; wtab[1] = 32'd8; wtab[2] = 32'd9;
    resp_tab[1] = 2'b10;
    start(32'h5000, 3);
    wait_done(80);
    repeat (2) @(negedge clk);
    check("t4_error_sticky", error, 1);
    check("t4_last_awaddr", last_awaddr, 32'h5008);
    resp_tab[1] = 2'b00;
    wtab[0] = 32'h12345678;
    start(32'h6000, 1);
    @(negedge clk);
    check("t4_error_cleared", error, 0);
    wait_done(50);
    repeat (2) @(negedge clk);

    // Zero-length request
    d0 = done_cnt;
    start(32'h3000, 0);
    @(negedge clk);
    check("len0_done", done, 1);
    check("len0_quiet", {awvalid, wvalid, bready, write_data_ready_out}, 4'b0);
    @(negedge clk);
    check("len0_idle", busy, 0);
    repeat (2) @(negedge clk);
    check("len0_done_once", done_cnt - d0, 1);

    // Address wrap
    wtab[0] = 32'h11; wtab[1] = 32'h22;
    start(32'hFFFFFFFC, 2);
    wait_done(60);
    repeat (2) @(negedge clk);
    check("wrap_awaddr", last_awaddr, 32'h00000000);

    // Stalled user data
    stall = 5;
    wtab[0] = 32'h77;
    start(32'h7000, 1);
    repeat (3) @(negedge clk);
    check("stall_ready", {busy, write_data_ready_out}, 2'b11);
    check("stall_quiet", {awvalid, wvalid, bready}, 3'b0);
    wait_done(60);
    repeat (2) @(negedge clk);
    check("stall_wdata", last_wdata, 32'h77);

    // Reset during SendAddrData
    wtab[0] = 32'hC0; wtab[1] = 32'hC1; wtab[2] = 32'hC2;
    start(32'h8000, 3);
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (awvalid) begin seen = 1; break; end
    end
    check("rst_reach_send", seen, 1);
    d0 = done_cnt;
    rst = 0;
    @(negedge clk);
    check("rst_mid_valids", {awvalid, wvalid, bready}, 3'b0);
    check("rst_mid_status", {busy, error, done}, 3'b0);
    exp_addr.delete(); exp_data.delete(); feed_q.delete();
    rst = 1;
    repeat (5) @(negedge clk);
    check("rst_no_done", done_cnt - d0, 0);

    // Recovery after reset
    wtab[0] = 32'hBEEF0009;
    start(32'h9000, 1);
    wait_done(50);
    repeat (2) @(negedge clk);
    check("recover_awaddr", last_awaddr, 32'h9000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
